// File: rtl/conv2_pkg.sv
// conv2_pkg: shared types and default geometry for the conv2 scheduler.
//   state_e          : scheduler FSM states
//   IMG_W/IMG_H/K    : input feature-map geometry and kernel size
//   CALC_LAT         : calc-unit valid-in to valid-out latency
//   CREDITS          : downstream output FIFO depth
//   OUT_W/OUT_H/OUT_N: derived output-map geometry
package conv2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int IMG_W    = 12;
  localparam int IMG_H    = 12;
  localparam int K        = 5;
  localparam int CALC_LAT = 8;
  localparam int CREDITS  = 16;

  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int OUT_N = OUT_W * OUT_H;

endpackage

// File: rtl/conv2_credit_ctr.sv
// conv2_credit_ctr: free-slot counter for the downstream output FIFO.
//   clk, rst : clock, synchronous active-high reset (loads CREDITS)
//   dec      : one output issued into the calc pipeline (only when avail)
//   inc      : downstream FIFO popped one entry
//   avail    : at least one credit left
//   ovf      : single-cycle pulse when a pop arrives with all credits home
module conv2_credit_ctr #(
  parameter int CREDITS = conv2_pkg::CREDITS
) (
  input  logic clk,
  input  logic rst,
  input  logic dec,
  input  logic inc,
  output logic avail,
  output logic ovf
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  logic [CW-1:0] credit_q, credit_d;

  always_comb begin
    credit_d = credit_q;
    ovf      = 1'b0;
    case ({dec, inc})
      2'b10: credit_d = credit_q - 1'b1;
      2'b01: begin
        // A pop with every credit already returned is a protocol error;
        // the count saturates rather than wrapping.
        if (credit_q == FULL) ovf = 1'b1;
        else                  credit_d = credit_q + 1'b1;
      end
      default: ; // idle, or issue and pop cancel out
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) credit_q <= FULL;
    else     credit_q <= credit_d;
  end

  assign avail = (credit_q != '0);

endmodule

// File: rtl/conv2_sched.sv
// conv2_sched: conv2 stage scheduler.
//   clk, rst         : clock, synchronous active-high reset
//   start            : frame start pulse, honoured in IDLE only
//   pix_valid        : upstream pixel triplet available
//   pix_ready        : pixel accepted this cycle
//   buf_shift        : advance the 5x5 line buffer (pix_valid & pix_ready)
//   calc_valid       : registered valid strobe to every calc unit
//   out_row, out_col : output position tag, valid with calc_valid
//   calc_done_in     : valid_out from calc unit 0
//   out_pop          : downstream FIFO consumed one entry
//   busy             : frame in RUN or DRAIN
//   done             : one-cycle frame completion pulse
//   err              : sticky protocol error
module conv2_sched #(
  parameter int IMG_W   = conv2_pkg::IMG_W,
  parameter int IMG_H   = conv2_pkg::IMG_H,
  parameter int K       = conv2_pkg::K,
  parameter int CREDITS = conv2_pkg::CREDITS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            pix_valid,
  output logic                            pix_ready,
  output logic                            buf_shift,
  output logic                            calc_valid,
  output logic [$clog2(IMG_H-K+1)-1:0]    out_row,
  output logic [$clog2(IMG_W-K+1)-1:0]    out_col,
  input  logic                            calc_done_in,
  input  logic                            out_pop,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  import conv2_pkg::*;

  localparam int FRAME_OUTS = (IMG_W - K + 1) * (IMG_H - K + 1);
  localparam int ROW_W  = $clog2(IMG_H + 1);
  localparam int COL_W  = $clog2(IMG_W);
  localparam int OROW_W = $clog2(IMG_H - K + 1);
  localparam int OCOL_W = $clog2(IMG_W - K + 1);
  localparam int CNT_W  = $clog2(FRAME_OUTS + 1);

  localparam logic [ROW_W-1:0] ROW_K1   = ROW_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_K1   = COL_W'(K - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] CNT_ALL  = CNT_W'(FRAME_OUTS);

  state_e state_q, state_d;

  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  returned_q, returned_d;
  logic              calc_valid_q, calc_valid_d;
  logic [OROW_W-1:0] out_row_q, out_row_d;
  logic [OCOL_W-1:0] out_col_q, out_col_d;
  logic              err_q, err_d;

  logic window_pix, last_pix, accept, issue;
  logic credit_avail, credit_ovf;

  // Current (not yet accepted) pixel position decides stall and issue.
  assign window_pix = (row_q >= ROW_K1) && (col_q >= COL_K1);
  assign last_pix   = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign accept     = pix_valid & pix_ready;
  assign issue      = accept & window_pix;
  assign buf_shift  = accept;

  conv2_credit_ctr #(
    .CREDITS (CREDITS)
  ) u_credit (
    .clk   (clk),
    .rst   (rst),
    .dec   (issue),
    .inc   (out_pop),
    .avail (credit_avail),
    .ovf   (credit_ovf)
  );

  // NOTE: sequential state uses non-blocking assignments and a synchronous
  // reset sampled on the clock edge, so every flop updates together.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && last_pix) state_d = DRAIN;
      // Looking at the incoming return lets done follow the last return
      // by a single cycle.
      DRAIN:   if (returned_d == CNT_ALL) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pix_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      RUN: begin
        // Only window pixels consume a credit; the rest never stall.
        pix_ready = credit_avail | ~window_pix;
        busy      = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    row_d        = row_q;
    col_d        = col_q;
    issued_d     = issued_q;
    returned_d   = returned_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    calc_valid_d = issue;
    err_d        = err_q;

    if (state_q == IDLE && start) begin
      row_d      = '0;
      col_d      = '0;
      issued_d   = '0;
      returned_d = '0;
    end

    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (issue) begin
      issued_d  = issued_q + 1'b1;
      out_row_d = OROW_W'(row_q - ROW_K1);
      out_col_d = OCOL_W'(col_q - COL_K1);
    end

    if (calc_done_in) returned_d = returned_d + 1'b1;

    // A return with nothing outstanding, a start mid-frame, or a pop
    // beyond the FIFO depth all latch the error until reset.
    if ((calc_done_in && (returned_q == issued_q)) || (start && busy) || credit_ovf)
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q        <= '0;
      col_q        <= '0;
      issued_q     <= '0;
      returned_q   <= '0;
      calc_valid_q <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      issued_q     <= issued_d;
      returned_q   <= returned_d;
      calc_valid_q <= calc_valid_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      err_q        <= err_d;
    end
  end

  assign calc_valid = calc_valid_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign err        = err_q;

endmodule

// File: tb/tb_conv2_sched.sv
// Directed bench for conv2_sched with a fixed-latency calc-unit model and a
// raster-order tag monitor.
module tb_conv2_sched;

  localparam int IMG_W = 12;
  localparam int K     = 5;
  localparam int LAT   = conv2_pkg::CALC_LAT;

  logic       clk = 1'b0;
  logic       rst, start, pix_valid;
  logic       pix_ready, buf_shift, calc_valid;
  logic [2:0] out_row, out_col;
  logic       calc_done_in, out_pop;
  logic       busy, done, err;

  // Stimulus controls for the calc-unit / FIFO model.
  logic auto_pop, pop_force, cd_force, mon_clr;

  int n_vec  = 0;
  int n_miss = 0;

  conv2_sched dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .buf_shift    (buf_shift),
    .calc_valid   (calc_valid),
    .out_row      (out_row),
    .out_col      (out_col),
    .calc_done_in (calc_done_in),
    .out_pop      (out_pop),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Calc pipeline model: valid-out LAT cycles after valid-in, FIFO pop one
  // cycle later. Its own reset drops in-flight outputs.
  logic [LAT-1:0] pipe;
  logic           pop_d;
  always @(posedge clk) begin
    if (rst) begin
      pipe  <= '0;
      pop_d <= 1'b0;
    end else begin
      pipe  <= {pipe[LAT-2:0], calc_valid};
      pop_d <= pipe[LAT-1];
    end
  end
  assign calc_done_in = pipe[LAT-1] | cd_force;
  assign out_pop      = auto_pop ? pop_d : pop_force;

  // Monitor: tracks accepted pixels in raster order and expects a tagged
  // calc_valid exactly one cycle after each window-pixel accept.
  int m_r, m_c, exp_row, exp_col, n_acc, n_cv, n_done, seq_err, last_row, last_col;
  bit exp_cv;
  always @(negedge clk) begin
    if (rst || mon_clr) begin
      m_r <= 0; m_c <= 0; exp_cv <= 1'b0; exp_row <= 0; exp_col <= 0;
      n_acc <= 0; n_cv <= 0; n_done <= 0; seq_err <= 0;
      last_row <= 0; last_col <= 0;
    end else begin
      if ((calc_valid !== exp_cv) ||
          (exp_cv && (int'(out_row) != exp_row || int'(out_col) != exp_col)))
        seq_err <= seq_err + 1;
      if (calc_valid) begin
        n_cv     <= n_cv + 1;
        last_row <= int'(out_row);
        last_col <= int'(out_col);
      end
      if (done) n_done <= n_done + 1;
      if (pix_valid && pix_ready) begin
        n_acc   <= n_acc + 1;
        exp_cv  <= (m_r >= K - 1) && (m_c >= K - 1);
        exp_row <= m_r - (K - 1);
        exp_col <= m_c - (K - 1);
        if (m_c == IMG_W - 1) begin
          m_c <= 0;
          m_r <= m_r + 1;
        end else begin
          m_c <= m_c + 1;
        end
      end else begin
        exp_cv <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pop_force = 1'b0; cd_force = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string p);
    check({p, "_rdy"},    int'(pix_ready),  0);
    check({p, "_shift"},  int'(buf_shift),  0);
    check({p, "_cv"},     int'(calc_valid), 0);
    check({p, "_row"},    int'(out_row),    0);
    check({p, "_col"},    int'(out_col),    0);
    check({p, "_busy"},   int'(busy),       0);
    check({p, "_done"},   int'(done),       0);
    check({p, "_err"},    int'(err),        0);
    check({p, "_credit"}, int'(dut.u_credit.credit_q), 16);
  endtask

  task automatic start_frame();
    start = 1'b1; mon_clr = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mon_clr = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && n_done == 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_frame(input string p);
    check({p, "_acc"},   n_acc,    144);
    check({p, "_ncv"},   n_cv,     64);
    check({p, "_seq"},   seq_err,  0);
    check({p, "_lrow"},  last_row, 7);
    check({p, "_lcol"},  last_col, 7);
    check({p, "_ndone"}, n_done,   1);
    check({p, "_busy"},  int'(busy), 0);
  endtask

  initial begin
    int hit;
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0;
    auto_pop = 1'b0; pop_force = 1'b0; cd_force = 1'b0; mon_clr = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("rst");

    // Full frame, continuous pixels, pops follow returns by one cycle.
    auto_pop = 1'b1;
    start_frame();
    pix_valid = 1'b1;
    wait_done(1000);
    pix_valid = 1'b0;
    check_frame("full");
    check("full_err", int'(err), 0);

    // No pops: 16 issues, stall at window pixel (6,4), one pop releases one.
    do_reset();
    auto_pop = 1'b0;
    start_frame();
    pix_valid = 1'b1;
    repeat (150) @(negedge clk);
    check("stall_ncv",  n_cv,  16);
    check("stall_acc",  n_acc, 76);
    check("stall_rdy",  int'(pix_ready), 0);
    check("stall_busy", int'(busy), 1);
    pop_force = 1'b1;
    @(posedge clk); #1;
    pop_force = 1'b0;
    repeat (30) @(negedge clk);
    check("pop1_ncv", n_cv,  17);
    check("pop1_acc", n_acc, 77);
    check("pop1_rdy", int'(pix_ready), 0);
    check("pop1_seq", seq_err, 0);
    check("pop1_err", int'(err), 0);
    do_reset();
    check_reset_state("stall_rst");

    // Issue and pop together at credits=5 (12th issue, pixel (5,7)).
    auto_pop = 1'b0;
    start_frame();
    pix_valid = 1'b1;
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_r == 5 && m_c == 7 && pix_ready) begin
        hit = 1;
        break;
      end
    end
    check("same_hit", hit, 1);
    pop_force = 1'b1;
    @(posedge clk); #1;
    pop_force = 1'b0;
    @(negedge clk);
    check("same_credit", int'(dut.u_credit.credit_q), 5);
    repeat (40) @(negedge clk);
    check("same_ncv", n_cv,  17);
    check("same_acc", n_acc, 77);
    check("same_rdy", int'(pix_ready), 0);
    do_reset();

    // ~30% pixel gaps: tags must still arrive in exact raster order.
    auto_pop = 1'b1;
    start_frame();
    for (int i = 0; i < 3000 && n_done == 0; i++) begin
      pix_valid = ($urandom_range(0, 99) < 70);
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_frame("gaps");

    // Reset mid-RUN after 40 pixels, then a clean frame.
    do_reset();
    start_frame();
    pix_valid = 1'b1;
    for (int i = 0; i < 200 && n_acc < 40; i++) @(negedge clk);
    check("abort_acc", n_acc, 40);
    rst = 1'b1; pix_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("abort");
    start_frame();
    pix_valid = 1'b1;
    wait_done(1000);
    pix_valid = 1'b0;
    check_frame("clean");
    check("clean_err", int'(err), 0);

    // start during RUN: err set, frame undisturbed.
    do_reset();
    start_frame();
    pix_valid = 1'b1;
    repeat (30) @(negedge clk);
    check("bstart_pre", int'(err), 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("bstart_err",  int'(err),  1);
    check("bstart_busy", int'(busy), 1);
    wait_done(1000);
    pix_valid = 1'b0;
    check_frame("bstart");
    check("bstart_sticky", int'(err), 1);
    do_reset();
    check("bstart_clr", int'(err), 0);

    // Spurious calc_done_in in IDLE.
    auto_pop = 1'b0;
    cd_force = 1'b1;
    @(posedge clk); #1;
    cd_force = 1'b0;
    @(negedge clk);
    check("spur_err", int'(err), 1);
    do_reset();
    check("spur_clr", int'(err), 0);

    // Extra pop with all 16 credits home.
    pop_force = 1'b1;
    @(posedge clk); #1;
    pop_force = 1'b0;
    @(negedge clk);
    check("ovf_err",    int'(err), 1);
    check("ovf_credit", int'(dut.u_credit.credit_q), 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
